// File: rtl/freq_hop_pkg.sv
// Shared types and default constants for the frequency-hop scheduler.
package freq_hop_pkg;

  localparam int unsigned DefTableDepth   = 16;
  localparam int unsigned DefDwellWidth   = 24;
  localparam int unsigned DefSettleCycles = 12;
  localparam int unsigned PhaseW          = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDwell
  } state_e;

endpackage

// File: rtl/freq_hop_table.sv
// Hop phase-increment table: one synchronous write port, one asynchronous read port, no reset.
module freq_hop_table #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic [$clog2(Depth)-1:0] rd_addr_i,
  output logic [Width-1:0]         rd_data_o
);

  logic [Width-1:0] mem_q [Depth];

  // Storage update; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/freq_hop_scheduler.sv
// Steps a DDS through a table of phase increments: settle, then dwell, per hop.
module freq_hop_scheduler
  import freq_hop_pkg::*;
#(
  parameter int unsigned TABLE_DEPTH   = DefTableDepth,
  parameter int unsigned DWELL_WIDTH   = DefDwellWidth,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_wr_addr,
  input  logic [15:0]                    cfg_wr_data,
  input  logic [$clog2(TABLE_DEPTH):0]   cfg_num_hops,
  input  logic [DWELL_WIDTH-1:0]         cfg_dwell,
  input  logic                           cfg_loop,
  input  logic                           start,
  input  logic                           stop,
  output logic [15:0]                    dds_phase_inc,
  output logic                           data_valid,
  output logic [$clog2(TABLE_DEPTH)-1:0] hop_index,
  output logic                           hop_strobe,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned AW      = $clog2(TABLE_DEPTH);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CntW    = (DWELL_WIDTH > SettleW) ? DWELL_WIDTH : SettleW;

  localparam logic [AW:0]      MaxHops    = (AW + 1)'(TABLE_DEPTH);
  localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE_CYCLES - 1);

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [AW:0]            num_hops_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   loop_q;
  logic [15:0]            phase_q;
  logic [AW-1:0]          idx_q;
  logic                   valid_q, strobe_q, busy_q, done_q;

  logic                   start_ok;
  logic                   last_hop;
  logic [AW-1:0]          next_idx;
  logic [AW-1:0]          rd_addr;
  logic [15:0]            rd_data;

  // Table write is suppressed while reset is held.
  freq_hop_table #(
    .Depth (TABLE_DEPTH),
    .Width (PhaseW)
  ) u_table (
    .clk_i     (clock),
    .wr_en_i   (cfg_wr_en & ~reset),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (cfg_wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Hop sequencing decode: which entry the next load reads.
  always_comb begin
    start_ok = (cfg_num_hops != '0) && (cfg_num_hops <= MaxHops);
    last_hop = ({1'b0, idx_q} == (num_hops_q - 1'b1));
    next_idx = last_hop ? '0 : idx_q + 1'b1;
    rd_addr  = (state_q == StDwell) ? next_idx : '0;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      num_hops_q <= '0;
      dwell_q    <= '0;
      loop_q     <= 1'b0;
      phase_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop && start_ok) begin
            num_hops_q <= cfg_num_hops;
            dwell_q    <= (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
            loop_q     <= cfg_loop;
            phase_q    <= rd_data;
            idx_q      <= '0;
            strobe_q   <= 1'b1;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            cnt_q      <= SettleLoad;
            state_q    <= StSettle;
          end
        end
        StSettle: begin
          if (stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= StDwell;
            valid_q <= 1'b1;
            cnt_q   <= CntW'(dwell_q) - CntW'(1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDwell: begin
          if (stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (cnt_q == '0) begin
            valid_q <= 1'b0;
            if (!last_hop || loop_q) begin
              idx_q    <= next_idx;
              phase_q  <= rd_data;
              strobe_q <= 1'b1;
              cnt_q    <= SettleLoad;
              state_q  <= StSettle;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dds_phase_inc = phase_q;
  assign hop_index     = idx_q;
  assign data_valid    = valid_q;
  assign hop_strobe    = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_freq_hop_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a hop-period model.
module tb_freq_hop_scheduler;

  localparam int Settle = 12;
  localparam int Depth  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic [4:0]  cfg_num_hops;
  logic [23:0] cfg_dwell;
  logic        cfg_loop;
  logic        start;
  logic        stop;
  logic [15:0] dds_phase_inc;
  logic        data_valid;
  logic [3:0]  hop_index;
  logic        hop_strobe;
  logic        busy;
  logic        done;

  freq_hop_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_num_hops  (cfg_num_hops),
    .cfg_dwell     (cfg_dwell),
    .cfg_loop      (cfg_loop),
    .start         (start),
    .stop          (stop),
    .dds_phase_inc (dds_phase_inc),
    .data_valid    (data_valid),
    .hop_index     (hop_index),
    .hop_strobe    (hop_strobe),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: position t counts cycles since the current hop's strobe.
  int unsigned m_tbl [Depth];
  bit          m_act;
  int          m_t, m_idx, m_nh, m_dwell;
  bit          m_loop;
  int unsigned m_phase;
  bit          m_strobe, m_done;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    int unsigned old_tbl [Depth];
    old_tbl = m_tbl;
    if (reset) begin
      m_act = 0; m_t = 0; m_idx = 0; m_nh = 0; m_dwell = 0; m_loop = 0;
      m_phase = 0; m_strobe = 0; m_done = 0;
      return;
    end
    m_strobe = 0;
    m_done   = 0;
    if (!m_act) begin
      if (start && !stop && cfg_num_hops >= 1 && int'(cfg_num_hops) <= Depth) begin
        m_nh     = int'(cfg_num_hops);
        m_dwell  = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        m_loop   = cfg_loop;
        m_act    = 1;
        m_t      = 0;
        m_idx    = 0;
        m_phase  = old_tbl[0];
        m_strobe = 1;
      end
    end else if (stop) begin
      m_act = 0;
    end else begin
      m_t++;
      if (m_t == Settle + m_dwell) begin
        if (m_idx < m_nh - 1 || m_loop) begin
          m_idx    = (m_idx + 1) % m_nh;
          m_t      = 0;
          m_phase  = old_tbl[m_idx];
          m_strobe = 1;
        end else begin
          m_act  = 0;
          m_done = 1;
        end
      end
    end
    if (cfg_wr_en) m_tbl[cfg_wr_addr] = cfg_wr_data;
  endtask

  // One clock: model advances with the DUT, outputs compared mid-cycle.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_val("busy", busy, m_act);
    check_val("data_valid", data_valid, (m_act && m_t >= Settle) ? 1 : 0);
    check_val("hop_strobe", hop_strobe, m_strobe);
    check_val("done", done, m_done);
    check_val("dds_phase_inc", dds_phase_inc, m_phase);
    check_val("hop_index", hop_index, m_idx);
  endtask

  task automatic quiet();
    reset = 0; cfg_wr_en = 0; start = 0; stop = 0;
  endtask

  task automatic do_start(input int nh, input int dw, input bit lp);
    cfg_num_hops = 5'(nh);
    cfg_dwell    = 24'(dw);
    cfg_loop     = lp;
    start        = 1;
    tick();
    start = 0;
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) m_tbl[i] = 0;
    quiet();
    cfg_wr_addr = 0; cfg_wr_data = 0; cfg_num_hops = 0; cfg_dwell = 0; cfg_loop = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_val("rst_phase", dds_phase_inc, 0);
    check_val("rst_busy", busy, 0);

    // Fill the table: entry i = (i+1)*0x100.
    for (int i = 0; i < Depth; i++) begin
      cfg_wr_en   = 1;
      cfg_wr_addr = 4'(i);
      cfg_wr_data = 16'((i + 1) * 16'h0100);
      tick();
    end
    cfg_wr_en = 0;

    // Single pass, three hops, dwell 4.
    do_start(3, 4, 0);
    check_val("p1_strobe_c1", hop_strobe, 1);
    check_val("p1_phase_c1", dds_phase_inc, 16'h0100);
    repeat (16) tick();
    check_val("p1_strobe_c17", hop_strobe, 1);
    check_val("p1_phase_c17", dds_phase_inc, 16'h0200);
    repeat (16) tick();
    check_val("p1_strobe_c33", hop_strobe, 1);
    repeat (15) tick();
    check_val("p1_busy_c48", busy, 1);
    check_val("p1_valid_c48", data_valid, 1);
    tick();
    check_val("p1_done_c49", done, 1);
    check_val("p1_busy_c49", busy, 0);
    check_val("p1_phase_held", dds_phase_inc, 16'h0300);
    repeat (3) tick();

    // Illegal hop counts and start+stop in IDLE are ignored.
    do_start(0, 4, 0);
    check_val("nh0_busy", busy, 0);
    do_start(17, 4, 0);
    check_val("nh17_busy", busy, 0);
    stop = 1;
    do_start(3, 4, 0);
    stop = 0;
    check_val("start_stop_busy", busy, 0);
    check_val("start_stop_strobe", hop_strobe, 0);

    // Looping run, rewrite entry 1 while hop 1 dwells, then stop mid-dwell.
    do_start(3, 4, 1);
    repeat (28) tick();
    cfg_wr_en = 1; cfg_wr_addr = 4'd1; cfg_wr_data = 16'h0AAA;
    tick();
    cfg_wr_en = 0;
    check_val("wr_live_phase", dds_phase_inc, 16'h0200);
    repeat (19) tick();
    check_val("wrap_strobe", hop_strobe, 1);
    check_val("wrap_phase", dds_phase_inc, 16'h0100);
    check_val("wrap_index", hop_index, 0);
    repeat (16) tick();
    check_val("reload_phase", dds_phase_inc, 16'h0AAA);
    repeat (13) tick();
    stop = 1;
    tick();
    stop = 0;
    check_val("stop_busy", busy, 0);
    check_val("stop_valid", data_valid, 0);
    check_val("stop_phase", dds_phase_inc, 16'h0AAA);

    // Dwell 0 behaves as 1, then reset in the middle of SETTLE.
    do_start(2, 0, 0);
    repeat (30) tick();
    do_start(2, 3, 0);
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    check_val("midrst_phase", dds_phase_inc, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      cfg_wr_en    = ($urandom_range(0, 3) == 0);
      cfg_wr_addr  = 4'($urandom_range(0, 15));
      cfg_wr_data  = 16'($urandom);
      cfg_num_hops = 5'($urandom_range(0, 17));
      cfg_dwell    = 24'($urandom_range(0, 5));
      cfg_loop     = 1'($urandom_range(0, 1));
      start        = ($urandom_range(0, 9) == 0);
      stop         = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
